pwm_multi_gen: RTL
==================

Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator. Shared prescaler and period counter; per-channel duty compare.
Period, prescale and duty are double-buffered (shadowed), so the motor/LED driver layer can update them without glitches.
Sits between the rover control registers and the motor-driver and indicator pins.
Replaces fixed-duty, fixed-period dividers.

Parameters:
NUM_CH, 5, number of PWM output channels (1..16)
CNT_W, 16, width of period counter, period and duty values
PRESC_W, 16, width of prescaler counter and prescale value

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
enable  in  1  run control; low holds counters at 0 and drives outputs low
prescale  in  PRESC_W  clk cycles per counter tick, minus 1
period  in  CNT_W  counter terminal value; PWM period = (period+1)*(prescale+1) clk cycles
duty  in  NUM_CH*CNT_W  per-channel compare values; channel i at [i*CNT_W +: CNT_W]
load  in  1  one-cycle strobe; captures prescale/period/duty into the pending buffer
pwm_out  out  NUM_CH  registered PWM outputs
period_tick  out  1  one-cycle pulse at each period boundary
count  out  CNT_W  current period counter value (debug/sync)
load_pending  out  1  high while captured values await application

Behaviour:
- Reset (async assert, sync release): prescaler=0, count=0, pwm_out=0, period_tick=0, load_pending=0; active and pending prescale/period/duty=0.
- Prescaler: presc_cnt counts 0..active_prescale. tick=1 when presc_cnt==active_prescale, then presc_cnt wraps to 0. active_prescale=0 gives a tick every clk.
- Counter: on tick, count increments. When count==active_period it wraps to 0 (the wrap event). active_period=0 holds count at 0, so every tick is a wrap.
- period_tick: registered; high for exactly one clk in the cycle after the wrap event.
- Compare: pwm_out[i] <= enable && (count < active_duty[i]), registered, one clk latency from count.
  - duty=0 gives constant 0.
  - duty>period gives constant 1 (100%).
  - Compare is unsigned, full CNT_W width, with no truncation.
- load: captures prescale, period and all duty channels into the pending buffer and sets load_pending.
  - A second load before application overwrites the pending values (newest wins).
- Application, pending to active in one clk; load_pending clears:
  - at a wrap event while enable=1;
  - on the first clk after load while enable=0 (immediate).
- load in the same clk as a wrap: the new values are pending and are applied at the next wrap, not the current one.
- enable falling: presc_cnt and count clear to 0 next clk; pwm_out=0 next clk; period_tick suppressed.
- enable rising: counting starts from count=0; the first period is full length.
- Changing the prescale/period/duty inputs without load has no effect.
- Reset mid-period: immediate return to reset state. Pending values are discarded.

Optional Feature:
Macro: PWM_CENTER_ALIGNED_EN
- Defined: the counter counts up 0..active_period, then down to 0 (direction register, reset = up).
  - The wrap/application event and period_tick occur at count==0 while counting down.
  - Period = 2*active_period ticks.
  - The compare rule is unchanged, giving symmetric pulses.
  - active_period=0 behaves as in edge mode.
- Undefined: edge-aligned up-count only; no direction register is synthesised.

Decomposition:
- Package pwm_pkg holds:
  - default widths (CNT_W_DEF, PRESC_W_DEF);
  - a duty slice helper function;
  - the counter-direction enum {DIR_UP, DIR_DOWN}.
- One sub-module is natural: pwm_prescaler (PRESC_W counter, enable/clear, tick output), reusable by other timing blocks.
- The channel compare stays a generate loop in the top module.

Test Plan:
- Duty compare, 10-clk period:
  - Stimulus: prescale=0, period=9; duty ch0=2, ch1=5, ch2=0, ch3=9, ch4=10; load with enable=0, then enable=1.
  - Response: ch0 high 2 of 10 clks, ch1 5/10, ch2 always 0, ch3 9/10, ch4 always 1. period_tick every 10 clks.
- Prescaler: prescale=3, period=9, duty ch0=5 → 40-clk period, ch0 high 20 clks; count advances every 4 clks.
- Glitch-free update:
  - Stimulus: mid-period (count=4), load period=19, duty ch0=10.
  - Response: the current period completes with old values; the new values take effect after the next period_tick; load_pending high in between.
- Load on wrap: load asserted in the wrap clk → old values used for one further full period, then the new values apply.
- Reset and enable:
  - reset low mid-period with count=7 → all outputs 0 immediately; pending values discarded.
  - enable low for 3 clks → count=0, pwm_out=0; first period after re-enable is full length.
- Center-aligned (PWM_CENTER_ALIGNED_EN): prescale=0, period=4, duty ch0=2 → count sequence 0,1,2,3,4,3,2,1,0…; ch0 high while count<2, centred on the bottom; period_tick every 8 clks.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM generator family.
// Used by pwm_prescaler and pwm_multi_gen.
package pwm_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int PRESC_W_DEF = 16;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // LSB position of channel ch in a flat duty bus of w-bit fields
    function automatic int duty_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Programmable clock-enable divider: pulses tick once every (terminal+1) clk while enabled.
// Clearing enable returns the divider to 0 on the next clk.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] terminal,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = enable && (cnt == terminal);

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with shared prescaler/period counter and shadowed settings.
// Optional centre-aligned (up/down) counting when PWM_CENTER_ALIGNED_EN is defined.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    load,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick,
    output logic [CNT_W-1:0]        count,
    output logic                    load_pending
);

    logic [PRESC_W-1:0]      act_prescale, pend_prescale;
    logic [CNT_W-1:0]        act_period,   pend_period;
    logic [NUM_CH*CNT_W-1:0] act_duty,     pend_duty;

    logic              tick;
    logic              wrap;
    logic              apply;
    logic [NUM_CH-1:0] duty_hit;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (reset),
        .enable   (enable),
        .terminal (act_prescale),
        .tick     (tick)
    );

`ifdef PWM_CENTER_ALIGNED_EN
    dir_e dir;

    // Period boundary is the bottom of the down-slope; a zero period wraps on every tick.
    assign wrap = tick && ((act_period == '0) || (dir == DIR_DOWN && count == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            dir   <= DIR_UP;
        end else if (!enable) begin
            count <= '0;
            dir   <= DIR_UP;
        end else if (tick) begin
            if (act_period == '0) begin
                count <= '0;
                dir   <= DIR_UP;
            end else if (dir == DIR_DOWN) begin
                if (count == '0) begin
                    count <= {{(CNT_W-1){1'b0}}, 1'b1};
                    dir   <= DIR_UP;
                end else begin
                    count <= count - 1'b1;
                end
            end else if (count >= act_period) begin
                count <= count - 1'b1;
                dir   <= DIR_DOWN;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
`else
    assign wrap = tick && (count == act_period);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (tick) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end
`endif

    // Shadow transfer only at a period boundary, or at once while stopped.
    assign apply = load_pending && (wrap || !enable);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_prescale  <= '0;
            act_period    <= '0;
            act_duty      <= '0;
            pend_prescale <= '0;
            pend_period   <= '0;
            pend_duty     <= '0;
            load_pending  <= 1'b0;
        end else begin
            if (apply) begin
                act_prescale <= pend_prescale;
                act_period   <= pend_period;
                act_duty     <= pend_duty;
            end
            // A load coinciding with a boundary stays pending for the next one.
            if (load) begin
                pend_prescale <= prescale;
                pend_period   <= period;
                pend_duty     <= duty;
                load_pending  <= 1'b1;
            end else if (apply) begin
                load_pending  <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign duty_hit[i] = (count < act_duty[duty_lsb(i, CNT_W) +: CNT_W]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
        end else begin
            pwm_out     <= enable ? duty_hit : '0;
            period_tick <= wrap;
        end
    end

endmodule
